// File: rtl/writeback_if.sv
// writeback_if -- bundles the memory-stage result handshake, the load data
// return path and the register-file write port of the writeback block.
//
//   master : upstream side (drives results and load data, sees ready/write)
//   slave  : writeback side (consumes results, drives ready and the write port)
//
//   input_valid_i   result valid from the memory stage
//   input_ready_o   writeback can accept a result this cycle
//   reg_write_i     result targets a register
//   reg_addr_i      destination register index
//   reg_data_i      non-load result value
//   load_i          result is a load, data follows on ldata_i
//   load_size_i     00 byte, 01 halfword, 10/11 word
//   load_unsigned_i 1 = zero-extend, 0 = sign-extend
//   load_offset_i   byte address bits [1:0]
//   ldata_valid_i   memory read data valid
//   ldata_i         memory read word, little-endian
//   write_o         register-file write strobe
//   waddr_o         register-file write index
//   wdata_o         register-file write data
interface writeback_if;
    logic        input_valid_i;
    logic        input_ready_o;
    logic        reg_write_i;
    logic [4:0]  reg_addr_i;
    logic [31:0] reg_data_i;
    logic        load_i;
    logic [1:0]  load_size_i;
    logic        load_unsigned_i;
    logic [1:0]  load_offset_i;
    logic        ldata_valid_i;
    logic [31:0] ldata_i;
    logic        write_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    modport master (
        output input_valid_i, reg_write_i, reg_addr_i, reg_data_i,
               load_i, load_size_i, load_unsigned_i, load_offset_i,
               ldata_valid_i, ldata_i,
        input  input_ready_o, write_o, waddr_o, wdata_o
    );

    modport slave (
        input  input_valid_i, reg_write_i, reg_addr_i, reg_data_i,
               load_i, load_size_i, load_unsigned_i, load_offset_i,
               ldata_valid_i, ldata_i,
        output input_ready_o, write_o, waddr_o, wdata_o
    );
endinterface

// File: rtl/writeback.sv
// writeback -- final pipeline stage. Retires non-load results one per cycle
// and, for loads, waits for the memory read word, extracts and extends the
// addressed byte/halfword, then writes the register file. Writes to x0 are
// suppressed. All register-file outputs are registered.
//
//   clk_i    sole clock, rising edge
//   rst_n_i  asynchronous active-low reset
//   bus      writeback_if.slave (result handshake, load data, write port)
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a result; non-loads retire next cycle
// WAIT_LOAD | load accepted, holding its fields until ldata_valid_i
module writeback (
    input  logic       clk_i,
    input  logic       rst_n_i,
    writeback_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        ready;
    logic        accept;
    logic        cap_en;

    logic        cap_reg_write;
    logic [4:0]  cap_addr;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [1:0]  cap_offset;

    logic        write_q;
    logic [4:0]  waddr_q;
    logic [31:0] wdata_q;
    logic        write_next;
    logic [4:0]  waddr_next;
    logic [31:0] wdata_next;

    function automatic logic [31:0] extract(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic        uns,
        input logic [1:0]  off
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        // halfword position comes from off[1] only; off[0] is ignored
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   result = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   result = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: result = word;
        endcase
        return result;
    endfunction

    // ready depends on state alone so upstream never sees a combinational
    // path from its own valid back to ready
    assign ready  = (state == IDLE);
    assign accept = bus.input_valid_i & ready;

    always_comb begin
        state_next = state;
        cap_en     = 1'b0;
        write_next = 1'b0;
        waddr_next = waddr_q;
        wdata_next = wdata_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.load_i) begin
                        cap_en     = 1'b1;
                        state_next = WAIT_LOAD;
                    end else if (bus.reg_write_i && (bus.reg_addr_i != 5'd0)) begin
                        write_next = 1'b1;
                        waddr_next = bus.reg_addr_i;
                        wdata_next = bus.reg_data_i;
                    end
                end
            end
            WAIT_LOAD: begin
                if (bus.ldata_valid_i) begin
                    state_next = IDLE;
                    if (cap_reg_write && (cap_addr != 5'd0)) begin
                        write_next = 1'b1;
                        waddr_next = cap_addr;
                        wdata_next = extract(bus.ldata_i, cap_size,
                                             cap_unsigned, cap_offset);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cap_reg_write <= 1'b0;
            cap_addr      <= 5'd0;
            cap_size      <= 2'd0;
            cap_unsigned  <= 1'b0;
            cap_offset    <= 2'd0;
        end else if (cap_en) begin
            cap_reg_write <= bus.reg_write_i;
            cap_addr      <= bus.reg_addr_i;
            cap_size      <= bus.load_size_i;
            cap_unsigned  <= bus.load_unsigned_i;
            cap_offset    <= bus.load_offset_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            write_q <= 1'b0;
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
        end else begin
            write_q <= write_next;
            waddr_q <= waddr_next;
            wdata_q <= wdata_next;
        end
    end

    assign bus.input_ready_o = ready;
    assign bus.write_o       = write_q;
    assign bus.waddr_o       = waddr_q;
    assign bus.wdata_o       = wdata_q;

endmodule
